// File: rtl/muldiv_if.sv
// muldiv_if
//   Handshake bundle between control_unit, the shared mult/div units and
//   muldiv_sequencer.
//   slave  : sequencer side. It receives the request and the unit status, and
//            drives the starts, mux selects, HiLo_load and status.
//   master : control_unit / unit side, with the opposite directions.
//   Signals: req_valid, req_op (0 = MULT, 1 = DIV), req_ready, busy,
//            mult_control/mult_stop, div_control/div_stop/div_zero,
//            sel_mux_hi, sel_mux_lo, HiLo_load, done, exc_div_zero, timeout,
//            cycle_count[CNT_W-1:0]
interface muldiv_if #(
   parameter int CNT_W = 6
);
   logic             req_valid;
   logic             req_op;
   logic             req_ready;
   logic             busy;
   logic             mult_control;
   logic             mult_stop;
   logic             div_control;
   logic             div_stop;
   logic             div_zero;
   logic             sel_mux_hi;
   logic             sel_mux_lo;
   logic             HiLo_load;
   logic             done;
   logic             exc_div_zero;
   logic             timeout;
   logic [CNT_W-1:0] cycle_count;

   modport slave (
      input  req_valid, req_op, mult_stop, div_stop, div_zero,
      output req_ready, busy, mult_control, div_control, sel_mux_hi,
             sel_mux_lo, HiLo_load, done, exc_div_zero, timeout, cycle_count
   );

   modport master (
      output req_valid, req_op, mult_stop, div_stop, div_zero,
      input  req_ready, busy, mult_control, div_control, sel_mux_hi,
             sel_mux_lo, HiLo_load, done, exc_div_zero, timeout, cycle_count
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Runs one MULT or DIV request at a time on the shared mult/div units. It
//   pulses the selected unit's start, waits for that unit's stop, steers the
//   Hi/Lo muxes and issues one HiLo_load. It then reports done, or reports
//   exc_div_zero when the divisor is zero.
//   Optional macro MULDIV_TIMEOUT_EN adds a WAIT-state abort after
//   TIMEOUT_CYCLES cycles, reported as a one-cycle timeout pulse.
// Ports
//   clk   : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : muldiv_if.slave (request, unit handshakes, selects, status)
// Every output is a register, so no input reaches an output combinationally.
//
// state     | meaning
// ----------+-------------------------------------------------------
// S_IDLE    | ready for a request; selects hold the last op
// S_START   | one-cycle start pulse to the selected unit; counter cleared
// S_WAIT    | counting cycles until the selected unit's stop / div_zero
// S_LOAD    | HiLo_load pulse
// S_DONE    | done pulse
// S_EXC     | divide-by-zero exception pulse, nothing loaded
// S_TIMEOUT | abort pulse, nothing loaded (MULDIV_TIMEOUT_EN only)
module muldiv_sequencer #(
   parameter int TIMEOUT_CYCLES = 48,
   parameter int CNT_W          = 6
) (
   input  logic     clk,
   input  logic     reset,
   muldiv_if.slave  bus
);

   if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_cnt_w_check
      $error("CNT_W too small for TIMEOUT_CYCLES");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_LOAD,
      S_DONE,
      S_EXC
`ifdef MULDIV_TIMEOUT_EN
      , S_TIMEOUT
`endif
   } state_t;

   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
`ifdef MULDIV_TIMEOUT_EN
   localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

   state_t           r_state;
   logic             r_op;
   logic             r_sel;
   logic [CNT_W-1:0] r_cnt;
   logic             r_req_ready;
   logic             r_busy;
   logic             r_mult_ctl;
   logic             r_div_ctl;
   logic             r_load;
   logic             r_done;
   logic             r_exc;
   logic             r_timeout;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_op        <= 1'b0;
         r_sel       <= 1'b0;
         r_cnt       <= '0;
         r_req_ready <= 1'b1;
         r_busy      <= 1'b0;
         r_mult_ctl  <= 1'b0;
         r_div_ctl   <= 1'b0;
         r_load      <= 1'b0;
         r_done      <= 1'b0;
         r_exc       <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_mult_ctl <= 1'b0;
         r_div_ctl  <= 1'b0;
         r_load     <= 1'b0;
         r_done     <= 1'b0;
         r_exc      <= 1'b0;
         r_timeout  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_op        <= bus.req_op;
                  r_sel       <= ~bus.req_op;
                  r_state     <= S_START;
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  // Start pulse is registered here so it appears in START.
                  r_mult_ctl  <= ~bus.req_op;
                  r_div_ctl   <= bus.req_op;
               end
            end
            S_START: begin
               r_cnt   <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_cnt != C_CNT_MAX) begin
                  r_cnt <= r_cnt + 1'b1;
               end
               // div_zero wins over div_stop. The other unit's stop is ignored.
               if (r_op && bus.div_zero) begin
                  r_state <= S_EXC;
                  r_exc   <= 1'b1;
               end else if (r_op ? bus.div_stop : bus.mult_stop) begin
                  r_state <= S_LOAD;
                  r_load  <= 1'b1;
               end
`ifdef MULDIV_TIMEOUT_EN
               else if (r_cnt == C_TO_LAST) begin
                  r_state   <= S_TIMEOUT;
                  r_timeout <= 1'b1;
               end
`endif
            end
            S_LOAD: begin
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
            S_DONE, S_EXC
`ifdef MULDIV_TIMEOUT_EN
            , S_TIMEOUT
`endif
            : begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b1;
               r_busy      <= 1'b0;
            end
            default: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready    = r_req_ready;
   assign bus.busy         = r_busy;
   assign bus.mult_control = r_mult_ctl;
   assign bus.div_control  = r_div_ctl;
   assign bus.sel_mux_hi   = r_sel;
   assign bus.sel_mux_lo   = r_sel;
   assign bus.HiLo_load    = r_load;
   assign bus.done         = r_done;
   assign bus.exc_div_zero = r_exc;
   assign bus.timeout      = r_timeout;
   assign bus.cycle_count  = r_cnt;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Sequences the shared mult and div units for the multicycle CPU and offloads MULT/DIV handshaking from control_unit.
- Accepts one request at a time and pulses the start line of the selected unit, then waits for that unit's stop.
- Steers the Hi/Lo select muxes, issues a single HiLo_load, and reports completion or divide-by-zero exception back to control_unit.

Parameters:
TIMEOUT_CYCLES, 48, WAIT-state cycles before abort (used only with MULDIV_TIMEOUT_EN)
CNT_W, 6, width of cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
req_valid  in  1  request from control_unit
req_op  in  1  0 = MULT, 1 = DIV
req_ready  out  1  high only in IDLE
busy  out  1  high in any state except IDLE
mult_control  out  1  start pulse to mult unit
mult_stop  in  1  mult unit finished
div_control  out  1  start pulse to div unit
div_stop  in  1  div unit finished
div_zero  in  1  div unit detected divisor 0
sel_mux_hi  out  1  Hi mux select: 0 = div, 1 = mult
sel_mux_lo  out  1  Lo mux select: 0 = div, 1 = mult
HiLo_load  out  1  Hi/Lo write enable
done  out  1  one-cycle completion pulse
exc_div_zero  out  1  one-cycle exception pulse
timeout  out  1  one-cycle abort pulse (feature)
cycle_count  out  CNT_W  WAIT cycles elapsed in current op

Behaviour:
Reset and general timing:
- Sampled on the clk edge while reset==0: state=IDLE, op latch=0.
- Outputs after reset: sel_mux_hi/lo=0, cycle_count=0, all pulse outputs 0, req_ready=1, busy=0.
- Reset mid-operation aborts with no HiLo_load, done or exception.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

State machine:
- IDLE: req_ready=1. On req_valid=1, latch req_op and go to START. req_valid is ignored in every other state; no queueing.
- START (1 cycle): mult_control=1 if op=0, else div_control=1. cycle_count<=0. Go to WAIT.
- WAIT: both control lines 0. cycle_count increments by 1 per cycle and saturates at all-ones.
  - op=1 and div_zero=1: go to EXC. div_zero has priority over div_stop in the same cycle.
  - Selected unit's stop=1: go to LOAD.
  - Stop from the non-selected unit is ignored. div_zero is ignored when op=0.
- LOAD (1 cycle): HiLo_load=1. Go to DONE.
- DONE (1 cycle): done=1. Go to IDLE.
- EXC (1 cycle): exc_div_zero=1, HiLo_load stays 0. Go to IDLE.
- TIMEOUT (1 cycle, feature only): timeout=1, HiLo_load stays 0. Go to IDLE.

Mux selects and counter:
- sel_mux_hi = sel_mux_lo = latched op inverted (mult->1, div->0).
- Updated when a request is accepted; held stable through LOAD and while IDLE until the next accept.
- cycle_count holds its last value in LOAD, DONE, EXC and IDLE; cleared only in START or reset.

Latency:
- Request accepted at edge 0 -> START in cycle 1 -> WAIT from cycle 2.
- Stop seen in WAIT cycle k -> HiLo_load in k+1, done in k+2, req_ready in k+3.
- Back-to-back minimum: a new request is accepted on the first IDLE cycle.

Optional Feature:
Macro MULDIV_TIMEOUT_EN.
- Defined: in WAIT, if cycle_count == TIMEOUT_CYCLES-1 and no stop/div_zero this cycle, go to TIMEOUT. Stop or div_zero in that same cycle takes precedence.
- Undefined: the TIMEOUT state is not built, timeout is tied to 0, and WAIT waits indefinitely.

Test Plan:
1. MULT: reset low 2 cycles; req_valid=1, req_op=0 at cycle 0; mult_stop=1 at cycle 34 -> mult_control=1 only in cycle 1; cycle_count=32 at cycle 34; HiLo_load=1 at 35 with sel_mux_hi=sel_mux_lo=1; done=1 at 36; req_ready=1 at 37.
2. DIV normal: req_op=1; div_stop=1 at cycle 10 -> div_control=1 only in cycle 1; HiLo_load=1 at 11 with sels=0; done=1 at 12; exc_div_zero never asserted.
3. DIV by zero: req_op=1; div_zero=1 and div_stop=1 together at cycle 5 -> exc_div_zero=1 at 6; HiLo_load=0 and done=0 throughout; req_ready=1 at 7.
4. Wrong-unit / busy: MULT in progress, div_stop=1 and req_valid=1 (op=1) at cycle 4 -> both ignored; div_control never asserted; completes only on mult_stop.
5. Reset mid-op: reset=0 during WAIT at cycle 8 -> cycle 9 state IDLE, sels=0, cycle_count=0, HiLo_load=0; a later mult_stop produces no HiLo_load.
6. Timeout (MULDIV_TIMEOUT_EN, TIMEOUT_CYCLES=48): MULT with no stop -> timeout=1 at cycle 50; HiLo_load=0; IDLE at 51. Without the macro, no timeout and busy stays high.
